// File: rtl/wta_sequencer_pkg.sv
// wta_sequencer_pkg: shared WTA register index map, FSM encoding and width defaults
package wta_sequencer_pkg;
  localparam int DW_DEF = 16;
  localparam int SW_DEF = 4;
  typedef enum logic [3:0] {
    WTA_NONE = 4'd0, WTA_N = 4'd1, WTA_M = 4'd2, WTA_P = 4'd3, WTA_R = 4'd4,
    WTA_ROW = 4'd5, WTA_COL = 4'd6, WTA_CURR = 4'd7, WTA_SUM = 4'd8, WTA_STA = 4'd9,
    WTA_STB = 4'd10, WTA_STC = 4'd11, WTA_A = 4'd12, WTA_B = 4'd13, WTA_R1 = 4'd14
  } wta_idx_e;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_CU_RD = 2'd1, ST_DBG_RD = 2'd2} state_e;
endpackage

// File: rtl/wta_beat_buf.sv
// wta_beat_buf: debug beat output register with a skid entry behind it
// Ports: push_i/in_i write a beat, ready_i consumes the head, valid_o/out_o present it,
// count_o reports how many entries are occupied (0..2).
module wta_beat_buf #(
  parameter int W = 21
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] in_i,
  input  logic         ready_i,
  output logic         valid_o,
  output logic [W-1:0] out_o,
  output logic [1:0]   count_o
);
  logic out_v_q, out_v_d, skid_v_q, skid_v_d, pop, fill_out;
  logic [W-1:0] out_q, out_d, skid_q, skid_d;
  always_comb begin
    pop = out_v_q & ready_i;
    // the head is refilled straight from the input only when nothing is queued behind it
    fill_out = pop ? ~skid_v_q : ~out_v_q;
    out_d = (pop & skid_v_q) ? skid_q : fill_out ? in_i : out_q;
    out_v_d = (pop & skid_v_q) | (fill_out ? push_i : out_v_q);
    skid_d = (push_i & ~fill_out) ? in_i : skid_q;
    skid_v_d = fill_out ? 1'b0 : pop ? push_i : (skid_v_q | push_i);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      out_q <= '0;
      skid_q <= '0;
    end else begin
      out_v_q <= out_v_d;
      skid_v_q <= skid_v_d;
      out_q <= out_d;
      skid_q <= skid_d;
    end
  assign valid_o = out_v_q;
  assign out_o = out_q;
  assign count_o = {1'b0, out_v_q} + {1'b0, skid_v_q};
endmodule

// File: rtl/wta_sequencer.sv
// wta_sequencer: shares the WTA source mux between CU register moves and debug dump bursts
// Ports: cu_req/cu_sel -> cu_ack/ac_load/ac_data (CU move); dbg_start/dbg_first/dbg_count
// start a burst streamed on dbg_valid/dbg_ready/dbg_data/dbg_idx/dbg_last with dbg_busy;
// wta_sel/wta_en drive the mux (registered), mux_data returns its output.
module wta_sequencer
  import wta_sequencer_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int SW = SW_DEF,
  parameter logic [SW-1:0] FIRST_IDX = SW'(WTA_N),
  parameter logic [SW-1:0] LAST_IDX = SW'(WTA_R1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cu_req,
  input  logic [SW-1:0] cu_sel,
  output logic          cu_ack,
  output logic          ac_load,
  output logic [DW-1:0] ac_data,
  input  logic          dbg_start,
  input  logic [SW-1:0] dbg_first,
  input  logic [SW-1:0] dbg_count,
  output logic          dbg_busy,
  output logic          dbg_valid,
  input  logic          dbg_ready,
  output logic [DW-1:0] dbg_data,
  output logic [SW-1:0] dbg_idx,
  output logic          dbg_last,
  output logic [SW-1:0] wta_sel,
  output logic          wta_en,
  input  logic [DW-1:0] mux_data
);
  state_e state_q, state_d;
  logic [SW-1:0] wta_sel_q, wta_sel_d, idx_q, idx_d, rem_q, rem_d;
  logic wta_en_q, busy_q, busy_d, last_cu_q, last_cu_d, rd_last_q, ac_load_q;
  logic [DW-1:0] ac_data_q;
  logic cu_el, dbg_el, cu_win, dbg_win, start_acc, pop;
  logic [1:0] buf_cnt;
  logic [2:0] occ;
  wta_beat_buf #(.W(DW + SW + 1)) u_buf (
    .clk(clk),
    .rst(rst),
    .push_i(state_q == ST_DBG_RD),
    .in_i({mux_data, wta_sel_q, rd_last_q}),
    .ready_i(dbg_ready),
    .valid_o(dbg_valid),
    .out_o({dbg_data, dbg_idx, dbg_last}),
    .count_o(buf_cnt)
  );
  assign pop = dbg_valid & dbg_ready;
  // beats held after this edge, including the read in flight; one more read fits only if at most one remains
  assign occ = 3'(buf_cnt) + 3'(state_q == ST_DBG_RD) - 3'(pop);
  always_comb begin
    start_acc = dbg_start & ~busy_q & (dbg_count != '0);
    // a request still high at the end of its own read cycle is the move already in progress
    cu_el = cu_req & (state_q != ST_CU_RD);
    dbg_el = busy_q & (rem_q != '0) & (occ <= 3'd1);
    dbg_win = dbg_el & (~cu_el | last_cu_q);
    cu_win = cu_el & ~dbg_win;
    state_d = cu_win ? ST_CU_RD : dbg_win ? ST_DBG_RD : ST_IDLE;
    wta_sel_d = cu_win ? cu_sel : dbg_win ? idx_q : '0;
    last_cu_d = cu_win | (last_cu_q & ~dbg_win);
    idx_d = start_acc ? dbg_first : !dbg_win ? idx_q : (idx_q >= LAST_IDX) ? FIRST_IDX : idx_q + 1'b1;
    rem_d = start_acc ? dbg_count : rem_q - SW'(dbg_win);
    busy_d = start_acc | (busy_q & ~(pop & dbg_last));
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= ST_IDLE;
      wta_sel_q <= '0;
      wta_en_q <= 1'b0;
      idx_q <= '0;
      rem_q <= '0;
      busy_q <= 1'b0;
      last_cu_q <= 1'b0;
      rd_last_q <= 1'b0;
      ac_load_q <= 1'b0;
      ac_data_q <= '0;
    end else begin
      state_q <= state_d;
      wta_sel_q <= wta_sel_d;
      wta_en_q <= state_d != ST_IDLE;
      idx_q <= idx_d;
      rem_q <= rem_d;
      busy_q <= busy_d;
      last_cu_q <= last_cu_d;
      rd_last_q <= dbg_win & (rem_q == SW'(1));
      ac_load_q <= state_q == ST_CU_RD;
      ac_data_q <= (state_q == ST_CU_RD) ? mux_data : '0;
    end
  assign wta_sel = wta_sel_q;
  assign wta_en = wta_en_q;
  assign ac_load = ac_load_q;
  assign cu_ack = ac_load_q;
  assign ac_data = ac_data_q;
  assign dbg_busy = busy_q;
endmodule

// File: tb/tb_wta_sequencer.sv
// tb_wta_sequencer: directed and randomized check of wta_sequencer against a queue-based model
module tb_wta_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cu_req, cu_ack, ac_load, dbg_start, dbg_busy, dbg_valid, dbg_ready, dbg_last, wta_en;
  logic [3:0] cu_sel, dbg_first, dbg_count, dbg_idx, wta_sel;
  logic [15:0] ac_data, dbg_data, mux_data;
  logic [15:0] regs [16];
  logic [20:0] bq [$];
  logic [15:0] cq [$];
  logic [20:0] prev_beat;
  int n_chk = 0;
  int n_fail = 0;
  int pops = 0;
  bit model_busy = 0;
  bit prev_stall = 0;

  always #5 clk = ~clk;

  wta_sequencer dut (
    .clk(clk), .rst(rst), .cu_req(cu_req), .cu_sel(cu_sel), .cu_ack(cu_ack),
    .ac_load(ac_load), .ac_data(ac_data), .dbg_start(dbg_start), .dbg_first(dbg_first),
    .dbg_count(dbg_count), .dbg_busy(dbg_busy), .dbg_valid(dbg_valid), .dbg_ready(dbg_ready),
    .dbg_data(dbg_data), .dbg_idx(dbg_idx), .dbg_last(dbg_last), .wta_sel(wta_sel),
    .wta_en(wta_en), .mux_data(mux_data)
  );

  function automatic logic [15:0] ref_data(input logic [3:0] s);
    return (s >= 4'd1 && s <= 4'd14) ? regs[s] : 16'h0;
  endfunction

  always_comb mux_data = wta_en ? ref_data(wta_sel) : 16'h0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (!rst) chk("busy", 64'(dbg_busy), 64'(model_busy));
  endtask

  task automatic cu_issue(input logic [3:0] sel);
    cu_req = 1'b1;
    cu_sel = sel;
    cq.push_back(ref_data(sel));
  endtask

  task automatic start_burst(input logic [3:0] first, input logic [3:0] cnt);
    logic [3:0] ix;
    dbg_start = 1'b1;
    dbg_first = first;
    dbg_count = cnt;
    ix = first;
    if (!model_busy && cnt != 4'd0) begin
      for (int k = 0; k < int'(cnt); k++) begin
        bq.push_back({ix, ref_data(ix), 1'(k == int'(cnt) - 1)});
        ix = (ix == 4'd14) ? 4'd1 : ix + 4'd1;
      end
      model_busy = 1;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, 64'({cu_ack, ac_load, ac_data, dbg_busy, dbg_valid, dbg_data, dbg_idx, dbg_last, wta_sel, wta_en}), 64'd0);
  endtask

  always @(negedge clk) begin
    if (rst) prev_stall = 0;
    else begin
      if (prev_stall) chk("hold", 64'({dbg_valid, dbg_idx, dbg_data, dbg_last}), 64'({1'b1, prev_beat}));
      if (dbg_valid && dbg_ready) begin
        chk("beat_expected", 64'(bq.size() != 0), 64'd1);
        if (bq.size() != 0) begin
          chk("beat", 64'({dbg_idx, dbg_data, dbg_last}), 64'(bq.pop_front()));
          pops++;
          if (bq.size() == 0) model_busy = 0;
        end
      end
      chk("ack_eq_load", 64'(cu_ack), 64'(ac_load));
      if (ac_load) begin
        chk("ack_expected", 64'(cq.size() != 0), 64'd1);
        if (cq.size() != 0) chk("ac_data", 64'(ac_data), 64'(cq.pop_front()));
      end
      prev_stall = dbg_valid & !dbg_ready;
      prev_beat = {dbg_idx, dbg_data, dbg_last};
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] e2 [4];
    int en_cnt, nd, p0, cu_wait, max_wait;
    bit prev_cu, have, is_cu;
    e2 = '{4'd12, 4'd13, 4'd14, 4'd1};
    cu_req = 0; cu_sel = 0; dbg_start = 0; dbg_first = 0; dbg_count = 0; dbg_ready = 0;
    for (int i = 0; i < 16; i++) regs[i] = 16'($urandom);
    regs[8] = 16'h1234;
    regs[3] = 16'hC0DE;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset_outs");
    rst = 0;
    step();
    // single CU move
    cu_issue(4'd8);
    step();
    chk("t1_wta_en", 64'(wta_en), 64'd1);
    chk("t1_wta_sel", 64'(wta_sel), 64'd8);
    chk("t1_no_load_yet", 64'(ac_load), 64'd0);
    step();
    chk("t1_load", 64'({ac_load, cu_ack}), 64'd3);
    chk("t1_data", 64'(ac_data), 64'h1234);
    chk("t1_en_off", 64'(wta_en), 64'd0);
    cu_req = 0;
    step();
    chk("t1_load_pulse", 64'(ac_load), 64'd0);
    // burst with ready held high
    dbg_ready = 1;
    start_burst(4'd12, 4'd4);
    step();
    dbg_start = 0;
    for (int i = 0; i < 10 && !dbg_valid; i++) step();
    for (int i = 0; i < 4; i++) begin
      chk("t2_valid", 64'(dbg_valid), 64'd1);
      chk("t2_idx", 64'(dbg_idx), 64'(e2[i]));
      chk("t2_last", 64'(dbg_last), 64'(i == 3));
      step();
    end
    chk("t2_busy_fall", 64'(dbg_busy), 64'd0);
    // backpressure on the first beat
    dbg_ready = 0;
    start_burst(4'd12, 4'd4);
    step();
    dbg_start = 0;
    for (int i = 0; i < 10 && !dbg_valid; i++) step();
    en_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      en_cnt += int'(wta_en);
      chk("t3_stall_idx", 64'({dbg_valid, dbg_idx}), 64'({1'b1, 4'd12}));
      step();
    end
    chk("t3_prefetch_le1", 64'(en_cnt <= 1), 64'd1);
    dbg_ready = 1;
    for (int i = 0; i < 30 && bq.size() != 0; i++) step();
    chk("t3_drained", 64'(bq.size()), 64'd0);
    step();
    chk("t3_idle", 64'(dbg_busy), 64'd0);
    // contention: CU held continuously against a 6-beat burst
    cu_issue(4'd3);
    start_burst(4'd7, 4'd6);
    step();
    dbg_start = 0;
    nd = 0; have = 0; prev_cu = 0;
    for (int i = 0; i < 80; i++) begin
      if (wta_en && nd < 6) begin
        is_cu = (wta_sel == 4'd3);
        if (!have) chk("t4_cu_first", 64'(is_cu), 64'd1);
        else chk("t4_alternate", 64'(is_cu), 64'(!prev_cu));
        prev_cu = is_cu;
        have = 1;
        if (!is_cu) nd++;
      end
      if (cu_ack) begin
        if (nd < 6) cu_issue(4'd3);
        else cu_req = 0;
      end
      if (!cu_req && bq.size() == 0 && cq.size() == 0) break;
      step();
    end
    chk("t4_dbg_reads", 64'(nd), 64'd6);
    chk("t4_done", 64'({bq.size() == 0, cq.size() == 0, cu_req}), 64'b110);
    step();
    // edge inputs
    start_burst(4'd5, 4'd0);
    step();
    dbg_start = 0;
    for (int i = 0; i < 4; i++) begin
      chk("t5_cnt0", 64'({dbg_busy, dbg_valid, wta_en}), 64'd0);
      step();
    end
    start_burst(4'd5, 4'd3);
    step();
    dbg_start = 0;
    start_burst(4'd2, 4'd7);
    step();
    dbg_start = 0;
    for (int i = 0; i < 30 && (bq.size() != 0 || dbg_busy); i++) step();
    chk("t5_ignored_start", 64'({dbg_busy, dbg_valid}), 64'd0);
    cu_issue(4'd15);
    step();
    step();
    chk("t5_sel15", 64'({ac_load, ac_data}), 64'({1'b1, 16'h0}));
    cu_req = 0;
    step();
    // async reset in mid-burst
    start_burst(4'd3, 4'd5);
    step();
    dbg_start = 0;
    p0 = pops;
    for (int i = 0; i < 20 && pops - p0 < 2; i++) step();
    chk("t6_two_beats", 64'(pops - p0), 64'd2);
    #2 rst = 1;
    #1;
    chk_all_zero("t6_async_reset");
    bq.delete();
    cq.delete();
    model_busy = 0;
    step();
    step();
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      chk("t6_no_resume", 64'({dbg_busy, dbg_valid, wta_en}), 64'd0);
      step();
    end
    start_burst(4'd1, 4'd2);
    step();
    dbg_start = 0;
    for (int i = 0; i < 20 && bq.size() != 0; i++) step();
    chk("t6_new_burst", 64'(bq.size()), 64'd0);
    // randomized traffic
    cu_wait = 0; max_wait = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      dbg_ready = ($urandom % 4) != 0;
      if (cu_req && cu_ack) begin
        if ($urandom % 2 == 0) cu_issue(4'($urandom % 16));
        else cu_req = 0;
      end else if (!cu_req && $urandom % 3 == 0) cu_issue(4'($urandom % 16));
      cu_wait = (cu_req && !cu_ack) ? cu_wait + 1 : 0;
      if (cu_wait > max_wait) max_wait = cu_wait;
      dbg_start = 0;
      if ($urandom % 12 == 0) start_burst(4'($urandom_range(1, 14)), 4'($urandom_range(0, 14)));
      step();
    end
    dbg_start = 0;
    dbg_ready = 1;
    for (int i = 0; i < 200 && (bq.size() != 0 || cu_req || cq.size() != 0); i++) begin
      if (cu_ack) cu_req = 0;
      step();
    end
    chk("rnd_drained", 64'({bq.size() == 0, cq.size() == 0, cu_req}), 64'b110);
    chk("rnd_cu_latency", 64'(max_wait <= 6), 64'd1);
    step();
    chk("rnd_idle", 64'({dbg_busy, dbg_valid}), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
